// File: rtl/button_event_ctrl_pkg.sv
// Shared definitions for the button event controller: event kinds, arbiter
// state encoding and the width helper used to size ids and counters.
package button_pkg;

    localparam logic EVT_PRESS = 1'b0;
    localparam logic EVT_LONG  = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

    localparam int N_BTN_DEF       = 4;
    localparam int DB_CYCLES_DEF   = 16;
    localparam int LONG_CYCLES_DEF = 1000;

    // clog2 with a floor of one bit, for ids and counter widths
    function automatic int width_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_event_ctrl_debounce.sv
// One button channel: two-flop synchronizer, debounce counter, hold counter
// and single-cycle press / long-hold strobes aligned to the edge they occur on.
module button_debounce
    import button_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic long_hold
);

    localparam int DB_W   = width_of(DB_CYCLES);
    localparam int HOLD_W = width_of(LONG_CYCLES + 1);

    logic              meta;
    logic              sync;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              flip;

    assign flip      = (sync != level) && (db_cnt == DB_W'(DB_CYCLES - 1));
    assign press     = flip && sync;
    // a release landing on the same edge cancels the long-hold strobe
    assign long_hold = level && !flip && (hold_cnt == HOLD_W'(LONG_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= btn_raw;
            sync <= meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level  <= 1'b0;
            db_cnt <= '0;
        end else if (sync == level) begin
            db_cnt <= '0;
        end else if (flip) begin
            level  <= sync;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // saturates at LONG_CYCLES so the long strobe fires only once per press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
        end else if (!level || flip) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_W'(LONG_CYCLES)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/button_event_ctrl.sv
// Multi-button front end: per-channel debounce, pending press/long bits with
// sticky overflow, and a round-robin arbiter onto one valid/ready event port.
module button_event_ctrl
    import button_pkg::*;
#(
    parameter int N_BTN       = N_BTN_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn_raw,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_long,
    output logic [N_BTN-1:0]         btn_level,
    output logic [N_BTN-1:0]         ovf,
    input  logic                     clr_ovf
);

    localparam int ID_W = $clog2(N_BTN);

    logic [N_BTN-1:0] press_strobe;
    logic [N_BTN-1:0] long_strobe;
    logic [N_BTN-1:0] pend_press;
    logic [N_BTN-1:0] pend_long;
    logic [N_BTN-1:0] clr_press;
    logic [N_BTN-1:0] clr_long;

    arb_state_t      state;
    arb_state_t      state_next;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] sel_id;
    logic [ID_W-1:0] cand;
    logic            sel_long;
    logic            found;
    logic            load;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_debounce #(
            .DB_CYCLES   (DB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES)
        ) u_debounce (
            .clk       (clk),
            .rst       (rst),
            .btn_raw   (btn_raw[i]),
            .level     (btn_level[i]),
            .press     (press_strobe[i]),
            .long_hold (long_strobe[i])
        );
    end

    // a bit being loaded this edge may be re-set without counting as overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_press <= '0;
            pend_long  <= '0;
            ovf        <= '0;
        end else begin
            pend_press <= (pend_press & ~clr_press) | press_strobe;
            pend_long  <= (pend_long & ~clr_long) | long_strobe;
            ovf        <= (ovf & ~{N_BTN{clr_ovf}})
                        | (press_strobe & pend_press & ~clr_press)
                        | (long_strobe & pend_long & ~clr_long);
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        sel_id     = '0;
        sel_long   = EVT_PRESS;
        found      = 1'b0;
        cand       = '0;
        clr_press  = '0;
        clr_long   = '0;

        for (int k = 1; k <= N_BTN; k++) begin
            cand = ID_W'((int'(last_grant) + k) % N_BTN);
            if (!found && (pend_press[cand] || pend_long[cand])) begin
                found    = 1'b1;
                sel_id   = cand;
                sel_long = pend_press[cand] ? EVT_PRESS : EVT_LONG;
            end
        end

        case (state)
            ST_IDLE: begin
                if (found) begin
                    load       = 1'b1;
                    state_next = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (evt_ready) begin
                    if (found) begin
                        load = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (load) begin
            if (sel_long == EVT_LONG) begin
                clr_long[sel_id] = 1'b1;
            end else begin
                clr_press[sel_id] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= ID_W'(N_BTN - 1);
            evt_id     <= '0;
            evt_long   <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                last_grant <= sel_id;
                evt_id     <= sel_id;
                evt_long   <= sel_long;
            end
        end
    end

    assign evt_valid = (state == ST_OFFER);

endmodule
